// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, bit indices and state encoding for the UART RX controller
package uart_pkg;

   localparam logic [3:0] ADDR_DATA   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_CTRL   = 4'h8;
   localparam logic [3:0] ADDR_THRESH = 4'hC;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_BRK_HALT  = 1;
   localparam int CTRL_IE_LVL    = 2;
   localparam int CTRL_IE_ERR    = 3;
   localparam int CTRL_FLUSH     = 4;

   localparam int ST_EMPTY    = 0;
   localparam int ST_FULL     = 1;
   localparam int ST_OVR      = 2;
   localparam int ST_BRK      = 3;
   localparam int ST_STATE_LO = 4;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } rx_ctrl_state_e;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - circular-buffer FIFO with flush and same-cycle push/pop at full and empty
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             do_push;
   logic             do_pop;

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_W'(DEPTH));
   assign level = level_q;
   assign head  = mem_q[rd_ptr_q];

   // A pop frees the slot a same-cycle push needs, so push at full is legal only alongside a real pop.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - CPU-facing UART receive controller: register bus, enable FSM, RX FIFO, error flags and irq
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int PAYLOAD_BITS = 8,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bus_req,
   input  logic                    bus_we,
   input  logic [3:0]              bus_addr,
   input  logic [31:0]             bus_wdata,
   output logic [31:0]             bus_rdata,
   output logic                    bus_rvalid,
   input  logic                    rx_valid,
   input  logic [PAYLOAD_BITS-1:0] rx_data,
   input  logic                    rx_break,
   output logic                    rx_en,
   output logic                    irq
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   rx_ctrl_state_e          state_q, state_d;
   logic [3:0]              ctrl_q;
   logic [LVL_W-1:0]        thresh_q;
   logic                    ovr_q;
   logic                    brk_q;
   logic [7:0]              ovr_cnt_q;
   logic                    rx_en_q;
   logic                    irq_q;
   logic                    rvalid_q;
   logic [31:0]             rdata_q, rdata_d;
   logic [31:0]             status;

   logic                    rd_req, wr_req;
   logic                    wr_ctrl, wr_status, wr_thresh;
   logic                    flush, pop, pop_eff;
   logic                    push_req, brk_evt, ovr_evt;
   logic                    clr_ovr, clr_brk;
   logic [PAYLOAD_BITS-1:0] fifo_head, head_masked;
   logic                    fifo_empty, fifo_full;
   logic [LVL_W-1:0]        fifo_level;
   logic                    unused_wdata;

   assign rd_req    = bus_req && !bus_we;
   assign wr_req    = bus_req && bus_we;
   assign wr_ctrl   = wr_req && (bus_addr == ADDR_CTRL);
   assign wr_status = wr_req && (bus_addr == ADDR_STATUS);
   assign wr_thresh = wr_req && (bus_addr == ADDR_THRESH);
   assign flush     = wr_ctrl && bus_wdata[CTRL_FLUSH];
   assign clr_ovr   = wr_status && bus_wdata[ST_OVR];
   assign clr_brk   = wr_status && bus_wdata[ST_BRK];
   assign pop       = rd_req && (bus_addr == ADDR_DATA);
   assign pop_eff   = pop && !fifo_empty;

   assign push_req = (state_q == RUN) && rx_valid && !rx_break;
   assign brk_evt  = (state_q == RUN) && rx_valid && rx_break;
   assign ovr_evt  = push_req && fifo_full && !pop_eff && !flush;

   assign unused_wdata = ^bus_wdata[31:5];

   uart_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .pop   (pop),
      .flush (flush),
      .wdata (rx_data),
      .head  (fifo_head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .level (fifo_level)
   );

   assign head_masked = fifo_head & {PAYLOAD_BITS{!fifo_empty}};

   always_comb begin
      status                     = '0;
      status[ST_EMPTY]           = fifo_empty;
      status[ST_FULL]            = fifo_full;
      status[ST_OVR]             = ovr_q;
      status[ST_BRK]             = brk_q;
      status[ST_STATE_LO +: 2]   = state_q;
      status[15:8]               = 8'(fifo_level);
      status[23:16]              = ovr_cnt_q;
   end

   always_comb begin
      rdata_d = '0;
      case (bus_addr)
         ADDR_DATA:   rdata_d = {fifo_empty, {(31-PAYLOAD_BITS){1'b0}}, head_masked};
         ADDR_STATUS: rdata_d = status;
         ADDR_CTRL:   rdata_d = {28'b0, ctrl_q};
         ADDR_THRESH: rdata_d = 32'(thresh_q);
         default:     rdata_d = '0;
      endcase
   end

   // HALT is left for RUN on the clearing write itself, not on the following cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         OFF:  if (ctrl_q[CTRL_EN]) state_d = RUN;
         RUN:  if (!ctrl_q[CTRL_EN]) state_d = OFF;
               else if (brk_evt && ctrl_q[CTRL_BRK_HALT]) state_d = HALT;
         HALT: if (!ctrl_q[CTRL_EN]) state_d = OFF;
               else if (clr_brk) state_d = RUN;
         default: state_d = OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= OFF;
         ctrl_q    <= '0;
         thresh_q  <= LVL_W'(1);
         ovr_q     <= 1'b0;
         brk_q     <= 1'b0;
         ovr_cnt_q <= '0;
         rx_en_q   <= 1'b0;
         irq_q     <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q <= state_d;
         rx_en_q <= (state_d == RUN);
         if (wr_ctrl) begin
            ctrl_q <= bus_wdata[3:0];
         end
         if (wr_thresh) begin
            thresh_q <= bus_wdata[LVL_W-1:0];
         end
         // A new event wins over a same-cycle clear so no error is lost.
         if (ovr_evt) begin
            ovr_q <= 1'b1;
            if (ovr_cnt_q != 8'hFF) begin
               ovr_cnt_q <= ovr_cnt_q + 8'd1;
            end
         end else if (clr_ovr) begin
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
         end
         if (brk_evt) begin
            brk_q <= 1'b1;
         end else if (clr_brk) begin
            brk_q <= 1'b0;
         end
         irq_q <= (ctrl_q[CTRL_IE_LVL] && (thresh_q != '0) && (fifo_level >= thresh_q)) ||
                  (ctrl_q[CTRL_IE_ERR] && (ovr_q || brk_q));
         rvalid_q <= rd_req;
         rdata_q  <= rd_req ? rdata_d : '0;
      end
   end

   assign bus_rdata  = rdata_q;
   assign bus_rvalid = rvalid_q;
   assign rx_en      = rx_en_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard testbench for uart_rx_ctrl
module tb_uart_rx_ctrl;

   localparam logic [3:0] A_DATA   = 4'h0;
   localparam logic [3:0] A_STATUS = 4'h4;
   localparam logic [3:0] A_CTRL   = 4'h8;
   localparam logic [3:0] A_THRESH = 4'hC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bus_req = 1'b0;
   logic        bus_we = 1'b0;
   logic [3:0]  bus_addr = '0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_break = 1'b0;
   logic        rx_en;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];

   always #5 clk = ~clk;

   uart_rx_ctrl #(.PAYLOAD_BITS(8), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_rvalid (bus_rvalid),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_break   (rx_break),
      .rx_en      (rx_en),
      .irq        (irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      string       n;
      logic [31:0] e;
      if (bus_rvalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: got rdata 0x%08h, expected no read response", bus_rdata);
         end else begin
            n = name_q.pop_front();
            e = exp_q.pop_front();
            check(n, bus_rdata, e);
         end
      end
   end

   function automatic logic [31:0] st(input logic e, input logic f, input logic o, input logic b,
                                      input logic [1:0] s, input logic [7:0] lvl, input logic [7:0] cnt);
      return {8'h00, cnt, lvl, 2'b00, s, b, o, f, e};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
      exp_q.push_back(e);
      name_q.push_back(n);
      tick();
      bus_req = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      tick();
      bus_req = 1'b0; bus_we = 1'b0; bus_wdata = '0;
   endtask

   task automatic rx(input logic [7:0] d, input logic b);
      rx_valid = 1'b1; rx_data = d; rx_break = b;
      tick();
      rx_valid = 1'b0; rx_break = 1'b0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no finish, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset state, enable, basic receive
      idle(3);
      check("reset_rx_en", 32'(rx_en), 0);
      check("reset_irq", 32'(irq), 0);
      check("reset_rvalid", 32'(bus_rvalid), 0);
      check("reset_rdata", bus_rdata, 0);
      rst_n = 1'b1;
      rd(A_STATUS, st(1, 0, 0, 0, 2'd0, 8'd0, 8'd0), "t1_status_reset");
      rd(A_CTRL, 32'h0, "t1_ctrl_reset");
      rd(A_THRESH, 32'h1, "t1_thresh_reset");
      rd(4'h2, 32'h0, "t1_unmapped");
      wr(A_CTRL, 32'h1);
      check("t1_rx_en_early", 32'(rx_en), 0);
      idle(1);
      check("t1_rx_en", 32'(rx_en), 1);
      rd(A_STATUS, st(1, 0, 0, 0, 2'd1, 8'd0, 8'd0), "t1_status_run");
      rx(8'h41, 0);
      rx(8'h42, 0);
      rd(A_DATA, 32'h41, "t1_data0");
      rd(A_DATA, 32'h42, "t1_data1");
      rd(A_DATA, 32'h8000_0000, "t1_data_empty");

      // 2: overrun
      for (int i = 0; i < 10; i++) rx(8'(i), 0);
      rd(A_STATUS, st(0, 1, 1, 0, 2'd1, 8'd8, 8'd2), "t2_status_ovr");
      for (int i = 0; i < 8; i++) rd(A_DATA, 32'(i), "t2_data");
      rd(A_STATUS, st(1, 0, 1, 0, 2'd1, 8'd0, 8'd2), "t2_status_sticky");
      wr(A_STATUS, 32'h4);
      rd(A_STATUS, st(1, 0, 0, 0, 2'd1, 8'd0, 8'd0), "t2_status_w1c");

      // 3: push and pop in the same cycle while full
      for (int i = 0; i < 8; i++) rx(8'h10 + 8'(i), 0);
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = A_DATA;
      exp_q.push_back(32'h10); name_q.push_back("t3_data_pushpop");
      rx_valid = 1'b1; rx_data = 8'hAA;
      tick();
      bus_req = 1'b0; rx_valid = 1'b0;
      rd(A_STATUS, st(0, 1, 0, 0, 2'd1, 8'd8, 8'd0), "t3_status_full");
      for (int i = 1; i < 8; i++) rd(A_DATA, 32'h10 + 32'(i), "t3_data");
      rd(A_DATA, 32'hAA, "t3_data_last");
      rd(A_DATA, 32'h8000_0000, "t3_data_empty");

      // 4: break halt and error interrupt
      wr(A_CTRL, 32'hB);
      rx(8'h33, 0);
      rx(8'h00, 1);
      check("t4_rx_en_halt", 32'(rx_en), 0);
      check("t4_irq_early", 32'(irq), 0);
      idle(1);
      check("t4_irq", 32'(irq), 1);
      rx(8'h44, 0);
      rd(A_STATUS, st(0, 0, 0, 1, 2'd2, 8'd1, 8'd0), "t4_status_halt");
      wr(A_STATUS, 32'h8);
      check("t4_rx_en_resume", 32'(rx_en), 1);
      idle(1);
      check("t4_irq_clear", 32'(irq), 0);
      rd(A_STATUS, st(0, 0, 0, 0, 2'd1, 8'd1, 8'd0), "t4_status_run");
      rd(A_DATA, 32'h33, "t4_data");
      rd(A_DATA, 32'h8000_0000, "t4_data_empty");

      // 5: level interrupt
      wr(A_THRESH, 32'h3);
      wr(A_CTRL, 32'h5);
      rd(A_THRESH, 32'h3, "t5_thresh");
      rx(8'h01, 0);
      rx(8'h02, 0);
      idle(1);
      check("t5_irq_below", 32'(irq), 0);
      rx(8'h03, 0);
      check("t5_irq_latency", 32'(irq), 0);
      idle(1);
      check("t5_irq_level", 32'(irq), 1);
      rd(A_DATA, 32'h01, "t5_data");
      idle(1);
      check("t5_irq_drop", 32'(irq), 0);

      // 6: flush beats push, then mid-burst reset
      rx(8'h04, 0);
      rx(8'h05, 0);
      rx(8'h06, 0);
      rd(A_STATUS, st(0, 0, 0, 0, 2'd1, 8'd5, 8'd0), "t6_status_five");
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = A_CTRL; bus_wdata = 32'h11;
      rx_valid = 1'b1; rx_data = 8'h55;
      tick();
      bus_req = 1'b0; bus_we = 1'b0; rx_valid = 1'b0;
      rd(A_STATUS, st(1, 0, 0, 0, 2'd1, 8'd0, 8'd0), "t6_status_flushed");
      rd(A_CTRL, 32'h1, "t6_ctrl_flush_reads0");
      rd(A_DATA, 32'h8000_0000, "t6_data_empty");
      wr(A_CTRL, 32'h5);
      for (int i = 0; i < 4; i++) rx(8'h61 + 8'(i), 0);
      idle(1);
      check("t6_irq_before_reset", 32'(irq), 1);
      check("t6_rx_en_before_reset", 32'(rx_en), 1);
      rx_valid = 1'b1; rx_data = 8'h70;
      rst_n = 1'b0;
      idle(2);
      check("t6_reset_rx_en", 32'(rx_en), 0);
      check("t6_reset_irq", 32'(irq), 0);
      check("t6_reset_rvalid", 32'(bus_rvalid), 0);
      check("t6_reset_rdata", bus_rdata, 0);
      rx_valid = 1'b0;
      rst_n = 1'b1;
      idle(1);
      rd(A_STATUS, st(1, 0, 0, 0, 2'd0, 8'd0, 8'd0), "t6_status_after_reset");
      rd(A_CTRL, 32'h0, "t6_ctrl_after_reset");
      rd(A_THRESH, 32'h1, "t6_thresh_after_reset");
      rd(A_DATA, 32'h8000_0000, "t6_data_after_reset");
      idle(3);
      check("t6_rx_en_stays_off", 32'(rx_en), 0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_reads: got %0d outstanding, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
